// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the double-dabble sequencing controller.
// Holds the state encoding and the BCD digit-range check.
package bcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int WIDTH_DEFAULT  = 8;
  localparam int DIGITS_DEFAULT = 3;
  // Upper bound on DIGITS; the range check works on a vector of this size.
  localparam int MAX_DIGITS     = 8;
  localparam logic [3:0] BCD_MAX_NIBBLE = 4'd9;

  // High when any of the low ndig nibbles is outside 0..9.
  function automatic logic nibble_err(input logic [4*MAX_DIGITS-1:0] bcd,
                                      input int ndig);
    logic err;
    err = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < ndig) && (bcd[4*i +: 4] > BCD_MAX_NIBBLE)) err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter, purely combinational.
// The requester that did not win last time has priority under contention.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end

endmodule

// File: rtl/bcd_seq_controller.sv
// Sequencer for the serial binary-to-BCD datapath: arbitrate, load/clear,
// step WIDTH shift cycles, capture the nibbles and hold them for the consumer.
module bcd_seq_controller
  import bcd_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [WIDTH-1:0]    req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [WIDTH-1:0]    req1_data,
  output logic                req1_ready,
  output logic                dp_load,
  output logic                dp_clear,
  output logic                dp_shift,
  output logic [WIDTH-1:0]    dp_data,
  input  logic [4*DIGITS-1:0] dp_bcd,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DIGITS-1:0] res_bcd,
  output logic                res_id,
  output logic                res_err,
  output logic                busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg;
  logic [WIDTH-1:0]      op_reg;
  logic                  last_grant_reg;
  logic                  res_valid_reg;
  logic                  res_id_reg;
  logic                  res_err_reg;
  logic [4*DIGITS-1:0]   res_bcd_reg;
  logic [1:0]            grant;
  logic                  idle;
  logic                  accept;
  logic [4*MAX_DIGITS-1:0] bcd_ext;

  rr_arbiter_2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign idle       = (state_reg == IDLE);
  assign accept     = idle & (|grant);
  // Readies are forced low while reset is held so every output reads 0.
  assign req0_ready = idle & grant[0] & ~reset;
  assign req1_ready = idle & grant[1] & ~reset;
  assign busy       = ~idle;
  assign res_valid  = res_valid_reg;
  assign res_bcd    = res_bcd_reg;
  assign res_id     = res_id_reg;
  assign res_err    = res_err_reg;
  assign bcd_ext    = (4*MAX_DIGITS)'(dp_bcd);

  always_comb begin
    state_next = state_reg;
    dp_load    = 1'b0;
    dp_clear   = 1'b0;
    dp_shift   = 1'b0;
    dp_data    = '0;
    case (state_reg)
      IDLE:    if (accept) state_next = LOAD;
      LOAD: begin
        dp_load    = 1'b1;
        dp_clear   = 1'b1;
        dp_data    = op_reg;
        state_next = SHIFT;
      end
      SHIFT: begin
        dp_shift = 1'b1;
        dp_data  = op_reg;
        if (cnt_reg == CNT_LAST) state_next = CAPTURE;
      end
      CAPTURE: state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      op_reg         <= '0;
      last_grant_reg <= 1'b1;
      res_valid_reg  <= 1'b0;
      res_id_reg     <= 1'b0;
      res_err_reg    <= 1'b0;
      res_bcd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg         <= grant[1] ? req1_data : req0_data;
            res_id_reg     <= grant[1];
            last_grant_reg <= grant[1];
          end
        end
        LOAD:  cnt_reg <= '0;
        SHIFT: cnt_reg <= cnt_reg + 1'b1;
        CAPTURE: begin
          res_bcd_reg   <= dp_bcd;
          res_err_reg   <= nibble_err(bcd_ext, DIGITS);
          res_valid_reg <= 1'b1;
        end
        HOLD: if (res_ready) res_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_controller.sv
// Directed bench for bcd_seq_controller with a behavioural double-dabble
// datapath model; expected BCD values are hand-computed constants.
module tb_bcd_seq_controller;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             dp_load, dp_clear, dp_shift;
  logic [WIDTH-1:0] dp_data;
  logic [11:0]      dp_bcd;
  logic             res_valid, res_ready, res_id, res_err, busy;
  logic [11:0]      res_bcd;

  int checks = 0;
  int errors = 0;

  bcd_seq_controller #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dp_load(dp_load), .dp_clear(dp_clear), .dp_shift(dp_shift), .dp_data(dp_data),
    .dp_bcd(dp_bcd),
    .res_valid(res_valid), .res_ready(res_ready), .res_bcd(res_bcd),
    .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural serial double-dabble datapath.
  logic [WIDTH-1:0] m_sr;
  logic [11:0]      m_bcd;
  logic             fault;

  function automatic logic [11:0] dd_step(input logic [11:0] b, input logic in_bit);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a[10:0], in_bit};
  endfunction

  always @(posedge clk) begin
    if (dp_load) begin
      m_sr  <= dp_data;
      m_bcd <= 12'h000;
    end else if (dp_shift) begin
      m_bcd <= dd_step(m_bcd, m_sr[WIDTH-1]);
      m_sr  <= {m_sr[WIDTH-2:0], 1'b0};
    end
  end

  assign dp_bcd = fault ? {m_bcd[11:4], 4'hC} : m_bcd;

  // Present one request and wait (bounded) for its handshake edge.
  task automatic issue(input bit id, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    if (id) begin req1_data = d; req1_valid = 1'b1; end
    else    begin req0_data = d; req0_valid = 1'b1; end
    for (int i = 0; i < 60; i++) begin
      #1;
      if ((id && req1_ready) || (!id && req0_ready)) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(negedge clk);
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Count cycles until res_valid, tallying datapath strobes on the way.
  task automatic wait_res(output int n, output int loads, output int shifts,
                          output int max_run);
    int run;
    n = -1; loads = 0; shifts = 0; max_run = 0; run = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dp_load) loads++;
      if (dp_shift) begin
        shifts++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (res_valid) begin n = i; break; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({res_valid, busy, dp_load, dp_clear, dp_shift, res_id, res_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {res_valid, busy, dp_load, dp_clear, dp_shift, res_id, res_err});
    end
    checks++;
    if (res_bcd !== 12'h000 || dp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got bcd=%h data=%h want 000/00", res_bcd, dp_data);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    bit ok; int n, l, s, r;
    res_ready = 1'b1;
    issue(1'b0, 8'hFF, ok);
    wait_res(n, l, s, r);
    checks++;
    if (!ok || n != 11) begin
      errors++;
      $display("FAIL single_latency got %0d want 11 (hs=%0b)", n, ok);
    end
    checks++;
    if (res_bcd !== 12'h255 || res_id !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL single_result got bcd=%h id=%b err=%b want 255/0/0",
               res_bcd, res_id, res_err);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release got busy=%b valid=%b want 0/0", busy, res_valid);
    end
    $display("single: FF -> %h id=%0d latency=%0d", res_bcd, res_id, n);
  endtask

  task automatic test_zero();
    bit ok; int n, l, s, r;
    issue(1'b1, 8'h00, ok);
    wait_res(n, l, s, r);
    checks++;
    if (!ok || res_bcd !== 12'h000 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL zero_result got bcd=%h id=%b hs=%0b want 000/1", res_bcd, res_id, ok);
    end
    checks++;
    if (l != 1) begin
      errors++;
      $display("FAIL zero_load_cycles got %0d want 1", l);
    end
    checks++;
    if (s != 8 || r != 8) begin
      errors++;
      $display("FAIL zero_shift_cycles got total=%0d run=%0d want 8/8", s, r);
    end
    @(posedge clk); #1;
    $display("zero: 00 -> %h id=%0d loads=%0d shifts=%0d", res_bcd, res_id, l, s);
  endtask

  task automatic test_contention();
    int n, l, s, r;
    bit          exp_id  [3] = '{1'b0, 1'b1, 1'b0};
    logic [11:0] exp_bcd [3] = '{12'h042, 12'h099, 12'h042};
    reset = 1'b1;
    req0_data = 8'h2A; req1_data = 8'h63;
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_res(n, l, s, r);
      checks++;
      if (n < 0 || res_id !== exp_id[k] || res_bcd !== exp_bcd[k]) begin
        errors++;
        $display("FAIL contention_%0d got id=%b bcd=%h want id=%b bcd=%h",
                 k, res_id, res_bcd, exp_id[k], exp_bcd[k]);
      end
      $display("contention: result %0d id=%0d bcd=%h", k, res_id, res_bcd);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    bit ok; int n, l, s, r; int bad;
    res_ready = 1'b0;
    issue(1'b0, 8'hFF, ok);
    wait_res(n, l, s, r);
    req1_data = 8'h11; req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_bcd !== 12'h255 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; bad++;
        $display("FAIL hold_cycle_%0d got v=%b bcd=%h busy=%b rdy=%b%b want 1/255/1/00",
                 i, res_valid, res_bcd, busy, req1_ready, req0_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got busy=%b valid=%b want 0/0", busy, res_valid);
    end
    req1_valid = 1'b0;
    @(negedge clk);
    $display("back_pressure: held 20 cycles, bad=%0d", bad);
  endtask

  task automatic test_reset_shift();
    bit ok; int n, l, s, r; int seen; bit stray;
    res_ready = 1'b1;
    issue(1'b0, 8'hFF, ok);
    seen = 0;
    for (int i = 0; i < 40 && seen < 5; i++) begin
      @(negedge clk);
      if (dp_shift) seen++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({res_valid, busy, dp_load, dp_clear, dp_shift, req0_ready, req1_ready} !== 7'b0 ||
        dp_data !== 8'h00 || res_bcd !== 12'h000 || res_id !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_shift got v=%b busy=%b ld=%b sh=%b data=%h (shifts=%0d) want all 0",
               res_valid, busy, dp_load, dp_shift, dp_data, seen);
    end
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid || busy) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_abandon got stray activity want none");
    end
    issue(1'b0, 8'h80, ok);
    wait_res(n, l, s, r);
    checks++;
    if (!ok || n != 11 || res_bcd !== 12'h128) begin
      errors++;
      $display("FAIL after_reset got bcd=%h lat=%0d want 128/11", res_bcd, n);
    end
    @(posedge clk); #1;
    $display("reset_shift: abandoned at shift %0d, then 80 -> %h", seen, res_bcd);
  endtask

  task automatic test_fault();
    bit ok; int n, l, s, r;
    fault = 1'b1;
    issue(1'b1, 8'hFF, ok);
    wait_res(n, l, s, r);
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_bcd !== 12'h25C) begin
      errors++;
      $display("FAIL fault_flag got v=%b err=%b bcd=%h want 1/1/25c", res_valid, res_err, res_bcd);
    end
    @(posedge clk); #1;
    fault = 1'b0;
    issue(1'b0, 8'h63, ok);
    wait_res(n, l, s, r);
    checks++;
    if (res_err !== 1'b0 || res_bcd !== 12'h099) begin
      errors++;
      $display("FAIL fault_clear got err=%b bcd=%h want 0/099", res_err, res_bcd);
    end
    @(posedge clk); #1;
    $display("fault: err flagged then cleared");
  endtask

  initial begin
    reset = 1'b1; fault = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_back_pressure();
    test_reset_shift();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
